// File: rtl/spmv_mem_arbiter_if.sv
// spmv_mem_arbiter_if
//   Bundles the three PE request-source FIFO handshakes and the shared
//   memory request/response port seen by spmv_mem_arbiter.
//
//   Parameter: ADDR_W - memory address width
//
//   Signals
//     st_valid/st_pop/st_data       MAC output FIFO (result stores)
//     x_valid/x_pop/x_addr          cache miss FIFO (x-vector loads)
//     m_valid/m_pop/m_addr/m_tag    sparse matrix decoder FIFO (matrix loads)
//     req_mem_ld/req_mem_st         registered request strobes
//     req_mem_addr/req_mem_d_or_tag request address and store data / load tag
//     req_mem_stall                 memory port almost full
//     rsp_mem_push                  one load response returned
//
//   Modports
//     master - arbiter side (drives pops and requests)
//     slave  - environment side (FIFOs and memory port)
interface spmv_mem_arbiter_if #(
  parameter int ADDR_W = 48
);
  logic              st_valid;
  logic              st_pop;
  logic [63:0]       st_data;

  logic              x_valid;
  logic              x_pop;
  logic [ADDR_W-1:0] x_addr;

  logic              m_valid;
  logic              m_pop;
  logic [ADDR_W-1:0] m_addr;
  logic [1:0]        m_tag;

  logic              req_mem_ld;
  logic              req_mem_st;
  logic [ADDR_W-1:0] req_mem_addr;
  logic [63:0]       req_mem_d_or_tag;
  logic              req_mem_stall;
  logic              rsp_mem_push;

  modport master (
    input  st_valid, st_data,
    input  x_valid, x_addr,
    input  m_valid, m_addr, m_tag,
    input  req_mem_stall, rsp_mem_push,
    output st_pop, x_pop, m_pop,
    output req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag
  );

  modport slave (
    output st_valid, st_data,
    output x_valid, x_addr,
    output m_valid, m_addr, m_tag,
    output req_mem_stall, rsp_mem_push,
    input  st_pop, x_pop, m_pop,
    input  req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag
  );
endinterface

// File: rtl/spmv_mem_arbiter.sv
// spmv_mem_arbiter
//   Shares the single PE memory request port between result stores (MAC
//   output FIFO), x-vector loads (cache miss FIFO) and matrix-stream loads
//   (sparse matrix decoder FIFO). One source is popped per cycle; the pop
//   choice is registered into stage 1 and the request is registered from
//   the FIFO q one cycle later, so a pop becomes a request two cycles on.
//   Stores walk a pointer from st_base up to st_end; loads are limited by
//   a response credit counter.
//
//   Optional feature: define SPMV_MEM_ARB_STARVE_EN to add anti-starvation
//   counters for the x and matrix sources (default: strict fixed priority).
//
//   Parameters
//     ADDR_W          memory address width
//     MAX_OUTSTANDING loads popped but not yet answered (<= 127)
//     STARVE_LIMIT    wait cycles before a starved source is promoted
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     enable              PE busy; gates new pops
//     st_base_ld          load store pointer (st_base) and end bound (st_end)
//     st_done             store pointer equals end bound
//     outstanding         current load credit count
//     bus                 source FIFOs and memory port (master modport)
module spmv_mem_arbiter #(
  parameter int ADDR_W          = 48,
  parameter int MAX_OUTSTANDING = 64,
  parameter int STARVE_LIMIT    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                st_base_ld,
  input  logic [ADDR_W-1:0]   st_base,
  input  logic [ADDR_W-1:0]   st_end,
  output logic                st_done,
  output logic [6:0]          outstanding,
  spmv_mem_arbiter_if.master  bus
);

  // The credit counter is 7 bits wide, so the limit must fit in it.
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 127 || STARVE_LIMIT < 1 || ADDR_W < 4) begin : g_bad_cfg
    $error("spmv_mem_arbiter: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ST,
    SRC_X,
    SRC_M
  } src_e;

  src_e              grant;
  src_e              s1_src;
  logic [ADDR_W-1:0] st_ptr;
  logic [ADDR_W-1:0] st_end_q;
  logic              pop_ok;
  logic              credit_ok;
  logic              st_elig;
  logic              x_elig;
  logic              m_elig;
  logic              load_pop;
  logic              rsp_take;

  assign st_done = (st_ptr == st_end_q);

  // Pops are also held off while rst_n is low so every output reads 0 in reset.
  assign pop_ok    = rst_n && enable && !bus.req_mem_stall;
  assign credit_ok = int'(outstanding) < MAX_OUTSTANDING;
  assign st_elig   = pop_ok && bus.st_valid;
  assign x_elig    = pop_ok && credit_ok && bus.x_valid;
  assign m_elig    = pop_ok && credit_ok && bus.m_valid;

`ifdef SPMV_MEM_ARB_STARVE_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] x_wait;
  logic [STARVE_W-1:0] m_wait;
  logic                x_starved;
  logic                m_starved;

  assign x_starved = int'(x_wait) >= STARVE_LIMIT;
  assign m_starved = int'(m_wait) >= STARVE_LIMIT;

  // Count cycles a load source sits valid without a grant; saturate at the
  // limit and clear once the source is finally popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_wait <= '0;
      m_wait <= '0;
    end else begin
      if (bus.x_pop) begin
        x_wait <= '0;
      end else if (bus.x_valid && !x_starved) begin
        x_wait <= x_wait + 1'b1;
      end
      if (bus.m_pop) begin
        m_wait <= '0;
      end else if (bus.m_valid && !m_starved) begin
        m_wait <= m_wait + 1'b1;
      end
    end
  end
`endif

  // Fixed priority store > x > matrix. Starved sources override it, applied
  // in reverse order so that x wins when both are starved.
  always_comb begin
    grant = SRC_NONE;
    if (st_elig) begin
      grant = SRC_ST;
    end else if (x_elig) begin
      grant = SRC_X;
    end else if (m_elig) begin
      grant = SRC_M;
    end
`ifdef SPMV_MEM_ARB_STARVE_EN
    if (m_starved && m_elig) begin
      grant = SRC_M;
    end
    if (x_starved && x_elig) begin
      grant = SRC_X;
    end
`endif
  end

  assign bus.st_pop = (grant == SRC_ST);
  assign bus.x_pop  = (grant == SRC_X);
  assign bus.m_pop  = (grant == SRC_M);
  assign load_pop   = bus.x_pop || bus.m_pop;

  // Stage 1 remembers which FIFO was popped; its q is valid next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_src <= SRC_NONE;
    end else begin
      s1_src <= grant;
    end
  end

  // Request register. Strobes default low; address and data hold their
  // last values on idle cycles and on stores discarded at st_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req_mem_ld       <= 1'b0;
      bus.req_mem_st       <= 1'b0;
      bus.req_mem_addr     <= '0;
      bus.req_mem_d_or_tag <= '0;
    end else begin
      bus.req_mem_ld <= 1'b0;
      bus.req_mem_st <= 1'b0;
      case (s1_src)
        SRC_ST: begin
          if (!st_done) begin
            bus.req_mem_st       <= 1'b1;
            bus.req_mem_addr     <= st_ptr;
            bus.req_mem_d_or_tag <= bus.st_data;
          end
        end
        SRC_X: begin
          bus.req_mem_ld       <= 1'b1;
          bus.req_mem_addr     <= bus.x_addr;
          bus.req_mem_d_or_tag <= 64'h1;
        end
        SRC_M: begin
          bus.req_mem_ld       <= 1'b1;
          bus.req_mem_addr     <= bus.m_addr;
          bus.req_mem_d_or_tag <= {61'b0, bus.m_tag, 1'b0};
        end
        default: begin
        end
      endcase
    end
  end

  // Store pointer only advances on an issued store; a reload wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_ptr   <= '0;
      st_end_q <= '0;
    end else if (st_base_ld) begin
      st_ptr   <= st_base;
      st_end_q <= st_end;
    end else if (s1_src == SRC_ST && !st_done) begin
      st_ptr <= st_ptr + ADDR_W'(8);
    end
  end

  // Load credits: a response at zero is ignored, pop+response cancel out.
  assign rsp_take = bus.rsp_mem_push && (outstanding != 7'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 7'd0;
    end else if (load_pop && !rsp_take) begin
      outstanding <= outstanding + 7'd1;
    end else if (!load_pop && rsp_take) begin
      outstanding <= outstanding - 7'd1;
    end
  end

endmodule
